// File: rtl/uart_num_parser.sv
// Turns the UART byte stream into signed decimal integers, one num_valid pulse per token.
// Malformed, over-long or out-of-range tokens give one num_err pulse; output pulses come one cycle after the byte.
module uart_num_parser #(
  parameter int DATA_W         = 8,
  parameter int MAX_DIGITS     = 3,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic [7:0]        rx_data,
  input  logic              rx_done,
  output logic [DATA_W-1:0] num_data,
  output logic              num_valid,
  output logic              num_err
);

  localparam int ACC_W  = DATA_W + 1;
  localparam int WIDE_W = DATA_W + 5;
  localparam int CNT_W  = $clog2(MAX_DIGITS + 2);
  localparam int TMR_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [WIDE_W-1:0] TEN     = WIDE_W'(10);
  localparam logic [WIDE_W-1:0] NEG_MAX = WIDE_W'(1) << (DATA_W - 1);
  localparam logic [WIDE_W-1:0] POS_MAX = NEG_MAX - WIDE_W'(1);
  localparam logic [TMR_W-1:0]  TMR_MAX = TMR_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_DIGITS);

  typedef enum logic [1:0] {IDLE, SIGN, DIGITS, DISCARD} state_t;

  state_t            state, state_nxt;
  logic [ACC_W-1:0]  acc, acc_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              neg, neg_nxt;
  logic [TMR_W-1:0]  timer, timer_nxt;
  logic [DATA_W-1:0] data_nxt;
  logic              valid_nxt, err_nxt;

  logic              is_digit, is_minus, is_delim, timeout, range_ok;
  logic [3:0]        digit;
  logic [WIDE_W-1:0] acc_mul;
  logic [ACC_W-1:0]  acc_signed;

  assign is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
  assign is_minus = (rx_data == 8'h2D);
  assign is_delim = (rx_data == 8'h20) || (rx_data == 8'h2C) || (rx_data == 8'h09) ||
                    (rx_data == 8'h0D) || (rx_data == 8'h0A);
  assign digit    = rx_data[3:0];

  // Computed wide so an out-of-range intermediate never wraps before the check.
  assign acc_mul    = {{(WIDE_W-ACC_W){1'b0}}, acc} * TEN + {{(WIDE_W-4){1'b0}}, digit};
  assign range_ok   = neg ? (acc_mul <= NEG_MAX) : (acc_mul <= POS_MAX);
  assign acc_signed = neg ? (~acc + ACC_W'(1)) : acc;
  assign timeout    = (state != IDLE) && (timer == TMR_MAX) && !rx_done;

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    neg_nxt   = neg;
    data_nxt  = num_data;
    valid_nxt = 1'b0;
    err_nxt   = 1'b0;

    if (rx_done || state == IDLE) timer_nxt = '0;
    else if (timer != TMR_MAX)    timer_nxt = timer + TMR_W'(1);
    else                          timer_nxt = timer;

    case (state)
      IDLE: if (rx_done) begin
        if (is_digit) begin
          state_nxt = DIGITS;
          acc_nxt   = ACC_W'(digit);
          cnt_nxt   = CNT_W'(1);
          neg_nxt   = 1'b0;
        end else if (is_minus) begin
          state_nxt = SIGN;
          acc_nxt   = '0;
          cnt_nxt   = '0;
          neg_nxt   = 1'b1;
        end else if (!is_delim) begin
          err_nxt   = 1'b1;
          state_nxt = DISCARD;
        end
      end
      SIGN: begin
        if (rx_done) begin
          if (is_digit) begin
            state_nxt = DIGITS;
            acc_nxt   = ACC_W'(digit);
            cnt_nxt   = CNT_W'(1);
          end else begin
            err_nxt   = 1'b1;
            state_nxt = is_delim ? IDLE : DISCARD;
          end
        end else if (timeout) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end
      end
      DIGITS: begin
        if (rx_done) begin
          if (is_digit) begin
            if (cnt == CNT_MAX || !range_ok) begin
              err_nxt   = 1'b1;
              state_nxt = DISCARD;
            end else begin
              acc_nxt = ACC_W'(acc_mul);
              cnt_nxt = cnt + CNT_W'(1);
            end
          end else if (is_delim) begin
            valid_nxt = 1'b1;
            data_nxt  = acc_signed[DATA_W-1:0];
            state_nxt = IDLE;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = DISCARD;
          end
        end else if (timeout) begin
          valid_nxt = 1'b1;
          data_nxt  = acc_signed[DATA_W-1:0];
          state_nxt = IDLE;
        end
      end
      DISCARD: if ((rx_done && is_delim) || timeout) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      neg       <= 1'b0;
      timer     <= '0;
      num_data  <= '0;
      num_valid <= 1'b0;
      num_err   <= 1'b0;
    end else if (clear) begin
      // num_data intentionally keeps the last emitted value.
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      neg       <= 1'b0;
      timer     <= '0;
      num_valid <= 1'b0;
      num_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      cnt       <= cnt_nxt;
      neg       <= neg_nxt;
      timer     <= timer_nxt;
      num_data  <= data_nxt;
      num_valid <= valid_nxt;
      num_err   <= err_nxt;
    end
  end

endmodule

// File: tb/tb_uart_num_parser.sv
// Directed bench for uart_num_parser: table of byte strings with expected pulses,
// plus hand sequences for latency, timeout, clear and reset corner cases.
module tb_uart_num_parser;

  logic       clk = 1'b0;
  logic       rst_n, clear, rx_done;
  logic [7:0] rx_data, num_data;
  logic       num_valid, num_err;

  uart_num_parser #(.DATA_W(8), .MAX_DIGITS(3), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .rx_data(rx_data), .rx_done(rx_done),
    .num_data(num_data), .num_valid(num_valid), .num_err(num_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [7:0] vals[$];
  int         errs = 0;
  int         both = 0;

  always @(negedge clk) begin
    if (num_valid) vals.push_back(num_data);
    if (num_err) errs++;
    if (num_valid && num_err) both++;
  end

  typedef struct {
    string      s;
    int         gap;
    int         nv;
    int         ne;
    logic [7:0] v [3];
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(string s, int gap, int nv, int ne,
                              logic [7:0] a, logic [7:0] b, logic [7:0] c);
    vec_t t;
    t.s = s; t.gap = gap; t.nv = nv; t.ne = ne;
    t.v[0] = a; t.v[1] = b; t.v[2] = c;
    return t;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output logic v, output logic e,
                           output logic [7:0] d);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    v = num_valid;
    e = num_err;
    d = num_data;
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic wait_pulse(input bit want_err, output int k, output logic [7:0] d);
    k = 0;
    d = 8'h00;
    while (k < 200) begin
      @(negedge clk);
      k++;
      if (want_err ? num_err : num_valid) begin
        d = num_data;
        break;
      end
    end
  endtask

  initial begin
    logic       v, e;
    logic [7:0] d, held;
    int         k;

    rst_n = 1'b0; clear = 1'b0; rx_done = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset num_data", num_data, 0);
    chk("reset num_valid", num_valid, 0);
    chk("reset num_err", num_err, 0);
    rst_n = 1'b1;

    vq.push_back(mk("12 ",      5, 1, 0, 8'd12,  8'd0, 8'd0));
    vq.push_back(mk("-128\n",   2, 1, 0, 8'h80,  8'd0, 8'd0));
    vq.push_back(mk("127,",     2, 1, 0, 8'd127, 8'd0, 8'd0));
    vq.push_back(mk("128 ",     2, 0, 1, 8'd0,   8'd0, 8'd0));
    vq.push_back(mk("-129 ",    2, 0, 1, 8'd0,   8'd0, 8'd0));
    vq.push_back(mk("1a2 3 ",   2, 1, 1, 8'd3,   8'd0, 8'd0));
    vq.push_back(mk("0012 ",    2, 0, 1, 8'd0,   8'd0, 8'd0));
    vq.push_back(mk("5,6,,-3 ", 1, 3, 0, 8'd5,   8'd6, 8'hFD));
    vq.push_back(mk("-0 ",      1, 1, 0, 8'd0,   8'd0, 8'd0));
    vq.push_back(mk("007\t",    1, 1, 0, 8'd7,   8'd0, 8'd0));
    vq.push_back(mk("+5 ",      2, 0, 1, 8'd0,   8'd0, 8'd0));
    vq.push_back(mk("--1 ",     1, 0, 1, 8'd0,   8'd0, 8'd0));
    vq.push_back(mk("- 4\r",    1, 1, 1, 8'd4,   8'd0, 8'd0));
    vq.push_back(mk("1-2 ",     1, 0, 1, 8'd0,   8'd0, 8'd0));
    vq.push_back(mk("999 ",     1, 0, 1, 8'd0,   8'd0, 8'd0));

    foreach (vq[n]) begin
      pulse_clear();
      vals.delete();
      errs = 0;
      for (int i = 0; i < vq[n].s.len(); i++) begin
        @(negedge clk);
        rx_data = vq[n].s[i];
        rx_done = 1'b1;
        if (vq[n].gap > 1) begin
          @(negedge clk);
          rx_done = 1'b0;
          repeat (vq[n].gap - 2) @(negedge clk);
        end
      end
      @(negedge clk);
      rx_done = 1'b0;
      repeat (4) @(negedge clk);
      chk($sformatf("vec%0d valid count", n), vals.size(), vq[n].nv);
      chk($sformatf("vec%0d err count", n), errs, vq[n].ne);
      for (int j = 0; j < vq[n].nv && j < vals.size(); j++)
        chk($sformatf("vec%0d value%0d", n, j), vals[j], vq[n].v[j]);
    end
    chk("valid and err never together", both, 0);

    // Exact latency and single-cycle width on "12 ".
    pulse_clear();
    send_byte("1", v, e, d);
    chk("12: no pulse on '1'", {v, e}, 0);
    send_byte("2", v, e, d);
    chk("12: no pulse on '2'", {v, e}, 0);
    send_byte(" ", v, e, d);
    chk("12: valid after space", v, 1);
    chk("12: data", d, 12);
    @(negedge clk);
    chk("12: pulse is one cycle", num_valid, 0);

    // Error lands one cycle after the offending byte.
    send_byte("1", v, e, d);
    send_byte("a", v, e, d);
    chk("1a: err after 'a'", {v, e}, 2'b01);
    send_byte(" ", v, e, d);
    chk("1a: delimiter silent in discard", {v, e}, 0);

    // Pending digit flushed by timeout.
    send_byte("7", v, e, d);
    wait_pulse(1'b0, k, d);
    chk("timeout 7: cycles to valid", k, 101);
    chk("timeout 7: data", d, 7);

    // Lone minus times out as an error and the parser is back in IDLE.
    send_byte("-", v, e, d);
    wait_pulse(1'b1, k, d);
    chk("timeout '-': cycles to err", k, 101);
    send_byte("3", v, e, d);
    send_byte(" ", v, e, d);
    chk("after '-' timeout: positive 3", {v, d}, {1'b1, 8'd3});

    // clear drops a partial token but keeps num_data.
    held = num_data;
    send_byte("4", v, e, d);
    send_byte("5", v, e, d);
    pulse_clear();
    chk("clear: num_data holds", num_data, held);
    chk("clear: no pulse", {num_valid, num_err}, 0);
    send_byte("6", v, e, d);
    send_byte(" ", v, e, d);
    chk("clear: next token is 6", {v, d}, {1'b1, 8'd6});

    // clear wins over a delimiter arriving in the same cycle.
    send_byte("8", v, e, d);
    @(negedge clk);
    rx_data = " "; rx_done = 1'b1; clear = 1'b1;
    @(negedge clk);
    rx_done = 1'b0; clear = 1'b0;
    chk("clear+rx_done: no pulse", {num_valid, num_err}, 0);
    chk("clear+rx_done: data holds", num_data, 8'd6);
    send_byte(" ", v, e, d);
    chk("clear+rx_done: token dropped", {v, e}, 0);

    // Reset mid-token.
    send_byte("9", v, e, d);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid reset num_data", num_data, 0);
    chk("mid reset pulses", {num_valid, num_err}, 0);
    rst_n = 1'b1;
    send_byte(" ", v, e, d);
    chk("mid reset: token dropped", {v, e}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
